// File: rtl/mm2s_cmd_gen_if.sv
// AXI read-address channel bundle between the MM2S command generator and memory.
interface mm2s_cmd_gen_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_W       = 4
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_W-1:0]       arid;
    logic                  arvalid;
    logic                  arready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready
    );
endinterface

// File: rtl/mm2s_cmd_gen.sv
// Splits per-channel byte ranges into AXI INCR read bursts, serving channels in order,
// never crossing a 4 KiB page and never exceeding MAX_BURST beats.
module mm2s_cmd_gen #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned N_CHANNELS = 16,
    parameter int unsigned DATA_BYTES = 64,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] rd_addr [N_CHANNELS],
    input  logic [ADDR_WIDTH-1:0] rd_size [N_CHANNELS],
    output logic                  core_ready,
    output logic                  done,
    mm2s_cmd_gen_if.master        m_axi
);

    localparam int unsigned ID_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int unsigned SHIFT = $clog2(DATA_BYTES);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - SHIFT);
    localparam logic [12:0]           PAGE     = 13'd4096;
    localparam logic [12:0]           MAX_B    = 13'(MAX_BURST);
    localparam logic [ID_W-1:0]       LAST_CH  = ID_W'(N_CHANNELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StIssue,
        StDone
    } state_e;

    state_e                state_q;
    logic [ID_W-1:0]       ch_q;
    logic [ADDR_WIDTH-1:0] snap_addr_q [N_CHANNELS];
    logic [ADDR_WIDTH-1:0] snap_size_q [N_CHANNELS];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remaining_q;
    logic [12:0]           len_q;

    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [ID_W-1:0]       arid_q;
    logic                  arvalid_q;
    logic                  done_q;
    logic                  core_ready_q;

    logic [12:0] page_room;
    logic [12:0] cap;
    logic [12:0] len;

    // Cursor is beat-aligned, so page_room is always at least one beat.
    always_comb begin
        page_room = (PAGE - {1'b0, addr_q[11:0]}) >> SHIFT;
        cap       = (page_room < MAX_B) ? page_room : MAX_B;
        len       = (remaining_q < ADDR_WIDTH'(cap)) ? remaining_q[12:0] : cap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            arvalid_q    <= 1'b0;
            done_q       <= 1'b0;
            core_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int i = 0; i < N_CHANNELS; i++) begin
                            snap_addr_q[i] <= rd_addr[i];
                            snap_size_q[i] <= rd_size[i];
                        end
                        ch_q         <= '0;
                        core_ready_q <= 1'b0;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    addr_q      <= snap_addr_q[ch_q] & ~LOW_MASK;
                    remaining_q <= snap_size_q[ch_q] >> SHIFT;
                    state_q     <= StCalc;
                end
                StCalc: begin
                    if (remaining_q == '0) begin
                        if (ch_q == LAST_CH) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            ch_q    <= ch_q + ID_W'(1);
                            state_q <= StLoad;
                        end
                    end else begin
                        len_q     <= len;
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(len - 13'd1);
                        arid_q    <= ch_q;
                        arvalid_q <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (m_axi.arready) begin
                        addr_q      <= addr_q + (ADDR_WIDTH'(len_q) << SHIFT);
                        remaining_q <= remaining_q - ADDR_WIDTH'(len_q);
                        arvalid_q   <= 1'b0;
                        state_q     <= StCalc;
                    end
                end
                StDone: begin
                    done_q       <= 1'b0;
                    core_ready_q <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(SHIFT);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arid    = arid_q;
    assign m_axi.arvalid = arvalid_q;
    assign done          = done_q;
    assign core_ready    = core_ready_q;

endmodule

// File: tb/tb_mm2s_cmd_gen.sv
// Directed bench for mm2s_cmd_gen with hand-computed burst lists and cycle counts.
module tb_mm2s_cmd_gen;

    localparam int unsigned NCH = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] rd_addr [NCH];
    logic [63:0] rd_size [NCH];
    logic        core_ready;
    logic        done;

    mm2s_cmd_gen_if #(.ADDR_WIDTH(64), .ID_W(4)) ar_bus ();

    mm2s_cmd_gen #(
        .ADDR_WIDTH(64),
        .N_CHANNELS(NCH),
        .DATA_BYTES(64),
        .MAX_BURST (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_size   (rd_size),
        .core_ready(core_ready),
        .done      (done),
        .m_axi     (ar_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_t;

    ar_t ar_q[$];
    int  done_cnt;
    int  n_checks;
    int  n_errors;

    always @(negedge clk) begin
        if (!rst && ar_bus.arvalid && ar_bus.arready) ar_q.push_back({ar_bus.araddr, ar_bus.arlen,
                                                                       ar_bus.arid});
        if (!rst && done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) begin
            rd_addr[i] = '0;
            rd_size[i] = '0;
        end
        ar_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle offset from the start pulse at which done and the first arvalid appear.
    task automatic wait_done(input int max_k, input int pulse_at, output int done_k,
                             output int first_ar);
        done_k   = 0;
        first_ar = 0;
        for (int k = 1; k <= max_k; k++) begin
            if (first_ar == 0 && ar_bus.arvalid) first_ar = k;
            if (done) begin
                done_k = k;
                break;
            end
            start = (k == pulse_at);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [63:0] a,
                            input logic [7:0] l, input logic [3:0] id);
        if (idx < ar_q.size()) begin
            check_eq({tag, "_addr"}, ar_q[idx].addr, a);
            check_eq({tag, "_len"}, 64'(ar_q[idx].len), 64'(l));
            check_eq({tag, "_id"}, 64'(ar_q[idx].id), 64'(id));
        end else begin
            check_eq({tag, "_missing"}, 64'(ar_q.size()), 64'(idx + 1));
        end
    endtask

    int dk;
    int fa;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        start           = 1'b0;
        ar_bus.arready  = 1'b1;
        clear_all();
        tick();
        tick();

        check_eq("rst_core_ready", 64'(core_ready), 64'd1);
        check_eq("rst_arvalid", 64'(ar_bus.arvalid), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_araddr", ar_bus.araddr, 64'd0);
        check_eq("rst_arlen", 64'(ar_bus.arlen), 64'd0);
        check_eq("rst_arid", 64'(ar_bus.arid), 64'd0);
        check_eq("rst_arsize", 64'(ar_bus.arsize), 64'd6);
        check_eq("rst_arburst", 64'(ar_bus.arburst), 64'd1);
        rst = 1'b0;
        tick();

        // Two full 64-beat bursts on ch0
        clear_all();
        rd_addr[0] = 64'h1000;
        rd_size[0] = 64'h2000;
        pulse_start();
        check_eq("busy_after_start", 64'(core_ready), 64'd0);
        wait_done(200, 0, dk, fa);
        check_eq("t1_first_ar", 64'(fa), 64'd3);
        check_eq("t1_done_cyc", 64'(dk), 64'd37);
        tick();
        check_eq("t1_ready_after", 64'(core_ready), 64'd1);
        check_eq("t1_done_low", 64'(done), 64'd0);
        check_eq("t1_n_ar", 64'(ar_q.size()), 64'd2);
        check_ar("t1_ar0", 0, 64'h1000, 8'd63, 4'd0);
        check_ar("t1_ar1", 1, 64'h2000, 8'd63, 4'd0);

        // 4 KiB page split
        clear_all();
        rd_addr[0] = 64'h0FC0;
        rd_size[0] = 64'h100;
        pulse_start();
        wait_done(200, 0, dk, fa);
        check_eq("t2_done_cyc", 64'(dk), 64'd37);
        tick();
        check_eq("t2_n_ar", 64'(ar_q.size()), 64'd2);
        check_ar("t2_ar0", 0, 64'h0FC0, 8'd0, 4'd0);
        check_ar("t2_ar1", 1, 64'h1000, 8'd2, 4'd0);

        // Sparse channels, unaligned address and partial beat truncated
        clear_all();
        rd_addr[3]  = 64'h3010;
        rd_size[3]  = 64'hBF;
        rd_addr[15] = 64'hF000_0040;
        rd_size[15] = 64'h80;
        pulse_start();
        wait_done(200, 0, dk, fa);
        check_eq("t3_first_ar", 64'(fa), 64'd9);
        check_eq("t3_done_cyc", 64'(dk), 64'd37);
        tick();
        check_eq("t3_n_ar", 64'(ar_q.size()), 64'd2);
        check_ar("t3_ar0", 0, 64'h3000, 8'd1, 4'd3);
        check_ar("t3_ar1", 1, 64'hF000_0040, 8'd1, 4'd15);

        // Backpressure: AR fields hold for 10 stalled cycles
        clear_all();
        rd_addr[0] = 64'h2000;
        rd_size[0] = 64'h40;
        ar_bus.arready = 1'b0;
        pulse_start();
        tick();
        tick();
        check_eq("t4_arvalid", 64'(ar_bus.arvalid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t4_hold", {ar_bus.araddr[31:0], 15'd0, ar_bus.arvalid, 4'd0, ar_bus.arid,
                                 ar_bus.arlen}, {32'h2000, 15'd0, 1'b1, 4'd0, 4'd0, 8'd0});
        end
        ar_bus.arready = 1'b1;
        wait_done(200, 0, dk, fa);
        check_eq("t4_done_seen", 64'(dk != 0), 64'd1);
        tick();
        check_eq("t4_n_ar", 64'(ar_q.size()), 64'd1);

        // All channels empty
        clear_all();
        pulse_start();
        wait_done(200, 0, dk, fa);
        check_eq("t5_done_cyc", 64'(dk), 64'd33);
        check_eq("t5_no_ar", 64'(fa), 64'd0);
        tick();
        check_eq("t5_ready_after", 64'(core_ready), 64'd1);

        // Mid-pass start is ignored
        clear_all();
        rd_size[0] = 64'h1000;
        pulse_start();
        wait_done(200, 6, dk, fa);
        check_eq("t6_done_cyc", 64'(dk), 64'd35);
        for (int i = 0; i < 6; i++) tick();
        check_eq("t6_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("t6_n_ar", 64'(ar_q.size()), 64'd1);
        check_eq("t6_ready", 64'(core_ready), 64'd1);

        // Reset during ISSUE
        clear_all();
        rd_size[0] = 64'h40;
        ar_bus.arready = 1'b0;
        pulse_start();
        tick();
        tick();
        check_eq("t7_arvalid_pre", 64'(ar_bus.arvalid), 64'd1);
        rst = 1'b1;
        tick();
        check_eq("t7_arvalid_rst", 64'(ar_bus.arvalid), 64'd0);
        check_eq("t7_ready_rst", 64'(core_ready), 64'd1);
        rst = 1'b0;
        ar_bus.arready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_eq("t7_no_done", 64'(done_cnt), 64'd0);
        check_eq("t7_no_ar", 64'(ar_q.size()), 64'd0);
        check_eq("t7_idle_valid", 64'(ar_bus.arvalid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mm2s_cmd_gen.md
MM2S_CMD_GEN -- requirements
Module: mm2s_cmd_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte-address and size width.
REQ-002 SHALL have parameter N_CHANNELS, default 16, number of read channels; ID_W = max(1, clog2(N_CHANNELS)).
REQ-003 SHALL have parameter DATA_BYTES, default 64, bytes per AXI beat; power of 2, range 1..4096.
REQ-004 SHALL have parameter MAX_BURST, default 64, max beats per burst; range 1..256.
REQ-005 SHALL have ports:
- clk  in  1  single clock (memory domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse requesting a read pass.
- rd_addr[N_CHANNELS]  in  ADDR_WIDTH  per-channel start byte address.
- rd_size[N_CHANNELS]  in  ADDR_WIDTH  per-channel byte count.
- core_ready  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse when a pass completes.
- m_axi_araddr  out  ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  beats minus one.
- m_axi_arsize  out  3  constant clog2(DATA_BYTES).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arid  out  ID_W  channel index.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, CALC, ISSUE, DONE; all outputs SHALL be driven from registers.
REQ-007 IDLE: core_ready=1. start=1 SHALL snapshot all rd_addr/rd_size, set ch=0, go to LOAD, and drive core_ready=0 the next cycle.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 LOAD: cursor addr = rd_addr[ch], with the low clog2(DATA_BYTES) bits forced to 0; remaining beats = rd_size[ch] >> clog2(DATA_BYTES), with partial beats truncated. Next state is CALC.
REQ-010 CALC, remaining=0: advance ch and go to LOAD, or go to DONE if ch=N_CHANNELS-1.
REQ-011 CALC, remaining>0: len = min(remaining, (4096 - addr[11:0])/DATA_BYTES, MAX_BURST). Register araddr=addr, arlen=len-1, arid=ch. Go to ISSUE.
REQ-012 ISSUE: arvalid=1. araddr/arlen/arid SHALL hold stable until arvalid&arready.
REQ-013 On the ISSUE handshake: addr += len*DATA_BYTES and remaining -= len; arvalid SHALL be 0 the next cycle; next state is CALC.
REQ-014 No burst SHALL cross a 4 KiB boundary, and the sum of arlen+1 per channel SHALL equal the truncated beat count.
REQ-015 Channels SHALL be served strictly in order 0..N_CHANNELS-1; each channel completes fully before the next starts.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE, with core_ready=1 on the following cycle.
REQ-017 Latency: start at cycle t, ch0 non-empty -> first arvalid at t+3. A zero-size channel costs 2 cycles (LOAD+CALC).
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no error is flagged.

Reset
REQ-019 While rst=1 at a clk edge: state=IDLE, ch=0, arvalid=0, araddr=0, arlen=0, arid=0, done=0, core_ready=1.
REQ-020 rst SHALL take priority over start and over the handshake. Reset mid-burst SHALL drop arvalid the next cycle, with no completion and no done pulse.
REQ-021 m_axi_arsize and m_axi_arburst SHALL be constant, including during reset.

Verification (DATA_BYTES=64, MAX_BURST=64, N_CHANNELS=16, arready=1 unless stated)
REQ-022 ch0 addr=0x1000, size=0x2000, others 0 -> AR (0x1000, len 63, id 0), then (0x2000, len 63, id 0); done at the end.
REQ-023 ch0 addr=0x0FC0, size=0x100 -> AR (0x0FC0, len 0), then (0x1000, len 2); 4 KiB split.
REQ-024 Only ch3 and ch15 size=0x80 -> exactly two ARs, arid 3 then 15, each len 1.
REQ-025 arready held 0 for 10 cycles during ISSUE -> araddr/arlen/arid/arvalid unchanged across all 10 cycles.
REQ-026 All sizes 0, start at cycle t -> no arvalid, done at t+33, core_ready=1 at t+34.
REQ-027 start pulsed mid-pass is ignored (single done). rst asserted mid-ISSUE -> arvalid=0 and core_ready=1 the next cycle, no done pulse.
